// File: rtl/sr_latch_driver.sv
// Turns a level request into one mutually exclusive S or R pulse, then checks the latch readback.
// Latency: done in the cycle after accept when the latch already matches, else PULSE_CYCLES+3 cycles after accept.
// Backpressure: req_ready is high only in IDLE; a req_valid seen while busy is dropped, not queued.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_value   request strobe and requested latch state (1 = set, 0 = reset)
//   req_ready             high in IDLE; accept on req_valid & req_ready
//   S, R                  registered drives to the latch, never both high
//   Q_fb, Qn_fb           latch readback
//   busy, done, err       not-IDLE flag, one-cycle completion pulse, status held until next accept
module sr_latch_driver #(
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_value,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic Q_fb,
  input  logic Qn_fb,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int MAX_CNT = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  // Terminal counts: the pulse counter starts at 1 on entry to PULSE,
  // the timeout counter starts at 0 on entry to CHECK.
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] CHECK_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          target;

  // Q and Qn must both agree with the wanted value; Q==Qn is never a match.
  function automatic logic fb_match(input logic v, input logic q, input logic qn);
    return (q == v) && (qn == ~v);
  endfunction

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      target <= 1'b0;
      S      <= 1'b0;
      R      <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          S <= 1'b0;
          R <= 1'b0;
          if (req_valid) begin
            target <= req_value;
            err    <= 1'b0;
            if (fb_match(req_value, Q_fb, Qn_fb)) begin
              // Latch already holds the value: complete without pulsing.
              done <= 1'b1;
            end else begin
              state <= ST_PULSE;
              S     <= req_value;
              R     <= ~req_value;
              cnt   <= CW'(1);
            end
          end
        end

        ST_PULSE: begin
          if (cnt >= PULSE_LAST) begin
            state <= ST_GUARD;
            S     <= 1'b0;
            R     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_GUARD: begin
          // One dead cycle lets the latch settle before readback.
          S     <= 1'b0;
          R     <= 1'b0;
          state <= ST_CHECK;
          cnt   <= '0;
        end

        ST_CHECK: begin
          S <= 1'b0;
          R <= 1'b0;
          if (fb_match(target, Q_fb, Qn_fb)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            err   <= 1'b0;
          end else if (cnt >= CHECK_LAST) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a clocked model of the SR latch.
// Latency: n/a.
// Backpressure: n/a.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic reset;
  logic req_valid;
  logic req_value;
  logic req_ready;
  logic S;
  logic R;
  logic Q_fb;
  logic Qn_fb;
  logic busy;
  logic done;
  logic err;

  // Latch model: follows registered S/R one edge later; can be preset or overridden.
  logic lq;
  logic preset_vld;
  logic preset_val;
  logic force_mode;
  logic force_q;
  logic force_qn;

  int n_checks = 0;
  int n_pass   = 0;
  logic started = 1'b0;

  sr_latch_driver #(.PULSE_CYCLES(2), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_value (req_value),
    .req_ready (req_ready),
    .S         (S),
    .R         (R),
    .Q_fb      (Q_fb),
    .Qn_fb     (Qn_fb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset_vld) lq <= preset_val;
    else if (S)     lq <= 1'b1;
    else if (R)     lq <= 1'b0;
  end

  assign Q_fb  = force_mode ? force_q  : lq;
  assign Qn_fb = force_mode ? force_qn : ~lq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Step one edge and settle; samples after this are "the next cycle".
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic v);
    preset_vld = 1'b1;
    preset_val = v;
    tick();
    preset_vld = 1'b0;
  endtask

  // Mutual exclusion of S and R every cycle once out of reset.
  always @(negedge clk) begin
    if (started) check("s_and_r_excl", {31'd0, S & R}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_value  = 1'b0;
    preset_vld = 1'b0;
    preset_val = 1'b0;
    force_mode = 1'b0;
    force_q    = 1'b0;
    force_qn   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    started = 1'b1;
    check("rst_S", S, 0);
    check("rst_R", R, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);

    // Set request from Q=0.
    preset(1'b0);
    req_value = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      check("set_S", S, (k <= 2) ? 1 : 0);
      check("set_R", R, 0);
      check("set_done", done, (k == 5) ? 1 : 0);
      check("set_ready", req_ready, (k == 5) ? 1 : 0);
    end
    check("set_err", err, 0);

    // Redundant request: latch already Q=1.
    req_value = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("skip_done", done, 1);
    check("skip_err", err, 0);
    check("skip_busy", busy, 0);
    check("skip_S", S, 0);
    check("skip_R", R, 0);
    tick();
    check("skip_done_clr", done, 0);
    check("skip_busy2", busy, 0);

    // Reset command from Q=1.
    req_value = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      check("clr_R", R, (k <= 2) ? 1 : 0);
      check("clr_S", S, 0);
      check("clr_done", done, (k == 5) ? 1 : 0);
    end
    check("clr_err", err, 0);

    // Stuck latch: Q=0, Qn=1 regardless of drive.
    force_mode = 1'b1;
    force_q    = 1'b0;
    force_qn   = 1'b1;
    req_value  = 1'b1;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      check("stuck_S", S, (k <= 2) ? 1 : 0);
      check("stuck_done", done, (k == 8) ? 1 : 0);
      check("stuck_busy", busy, (k == 8) ? 0 : 1);
    end
    check("stuck_err", err, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stuck_err_hold", err, 1);
      check("stuck_done_low", done, 0);
    end

    // Invalid feedback Q=Qn=1: never matches, times out; accept clears err.
    force_q  = 1'b1;
    force_qn = 1'b1;
    req_value = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("inval_err_clr", err, 0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("inval_done", done, (k == 8) ? 1 : 0);
    end
    check("inval_err", err, 1);

    // Reset during PULSE.
    force_mode = 1'b0;
    preset(1'b1);
    req_value = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_R_pulse", R, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_R", R, 0);
    check("mid_S", S, 0);
    check("mid_ready", req_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_err", err, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_done", done, 0);
      check("mid_no_R", R, 0);
    end

    // Held req_valid while busy is ignored; request in done cycle is accepted.
    preset(1'b0);
    req_value = 1'b1;
    req_valid = 1'b1;
    tick();
    req_value = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      check("b2b_S", S, (k <= 2) ? 1 : 0);
      check("b2b_R", R, 0);
      check("b2b_ready", req_ready, (k == 5) ? 1 : 0);
      check("b2b_done", done, (k == 5) ? 1 : 0);
    end
    for (int k = 6; k <= 10; k++) begin
      tick();
      if (k == 6) req_valid = 1'b0;
      check("b2b2_R", R, (k == 6 || k == 7) ? 1 : 0);
      check("b2b2_S", S, 0);
      check("b2b2_done", done, (k == 10) ? 1 : 0);
    end
    check("b2b2_err", err, 0);
    check("b2b2_q", {31'd0, lq}, 0);

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked controller that drives the S/R inputs of an asynchronous SR latch. It turns a level request ("make Q = v") into a single, width-controlled, mutually exclusive set or reset pulse.
- After pulsing, it reads back Q/Qn and reports completion or failure.
- Sits between synchronous control logic and the gate-level latch cells. It is the only agent allowed to drive S/R, and it guarantees the forbidden S=R=1 input never occurs.

Parameters:
- PULSE_CYCLES, 2, number of clock cycles S or R is held high per pulse; legal range >= 1.
- TIMEOUT, 4, maximum number of CHECK cycles spent waiting for latch feedback to match; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe; only meaningful while req_ready=1.
- req_value  input  1  requested latch state: 1 = set (Q=1), 0 = reset (Q=0).
- req_ready  output  1  high only in IDLE; a request is accepted on the edge where req_valid & req_ready.
- S  output  1  registered set drive to the latch.
- R  output  1  registered reset drive to the latch.
- Q_fb  input  1  latch Q readback.
- Qn_fb  input  1  latch Qn readback.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  completion status, qualified by done; held until the next accepted request.

Behaviour:
- Reset (synchronous, edge where reset=1):
  - State goes to IDLE.
  - S=0, R=0, done=0, err=0, busy=0, req_ready=1.
  - All counters are cleared.
  - The stored target bit is cleared to 0.
- Reset asserted mid-operation:
  - The pulse is abandoned; S/R are 0 from the next cycle.
  - No done is generated.
- States: IDLE, PULSE, GUARD, CHECK.
- Feedback "match" means Q_fb==target AND Qn_fb==~target. Q_fb==Qn_fb never matches.
- IDLE:
  - req_ready=1.
  - On accept at edge t, latch target=req_value and clear err.
  - If feedback already matches req_value: no pulse; stay IDLE; done=1, err=0 in cycle t+1.
  - Otherwise: go to PULSE at t+1.
- PULSE:
  - S=target and R=~target, registered, held for exactly PULSE_CYCLES cycles (cycles t+1 .. t+PULSE_CYCLES).
  - Then go to GUARD.
- GUARD:
  - S=R=0 for exactly one cycle (t+PULSE_CYCLES+1).
  - Then go to CHECK; the timeout counter is cleared.
- CHECK:
  - S=R=0; feedback is evaluated every cycle.
  - On match: go to IDLE at the next edge; done=1, err=0 in that first IDLE cycle.
  - No match after TIMEOUT CHECK cycles: go to IDLE; done=1, err=1.
  - With ideal feedback, done is asserted in cycle t+PULSE_CYCLES+3.
- Invariants:
  - S&R==0 in every cycle.
  - S and R are never high outside PULSE.
  - done is high only in the first IDLE cycle after completion.
  - req_valid while req_ready=0 is ignored; it is not queued.
- Back-to-back requests:
  - A request may be accepted in the same cycle done is high, since the FSM is in IDLE.
  - In that case err clears at the next edge.
- Counters:
  - Width is clog2(max(PULSE_CYCLES,TIMEOUT))+1.
  - Counters saturate and never wrap.

Test Plan:
- Reset with S=R=0 expected, then set request: reset 2 cycles; req_valid=1, req_value=1 at t, model latch (Q_fb=0, Qn_fb=1) -> S=1 during t+1..t+2, R=0 throughout, GUARD at t+3, feedback flips, done=1 & err=0 at t+5, req_ready=1 at t+5.
- Redundant request skip: latch holds Q=1, request value=1 -> S and R stay 0, done=1 & err=0 at t+1, busy never asserts.
- Reset command: latch Q=1, request value=0 -> R=1 for exactly 2 cycles, S=0 throughout, done at t+5 with err=0.
- Stuck latch timeout: Q_fb forced 0, Qn_fb forced 1, request value=1 -> S pulse 2 cycles, 4 CHECK cycles, done=1 & err=1 at t+8; err stays 1 until the next accepted request.
- Invalid feedback plus mid-operation reset: Q_fb=Qn_fb=1 during CHECK -> timeout, err=1. Separately, assert reset during PULSE -> S=0 the next cycle, no done, req_ready=1.
- Back-to-back and ignored requests:
  - Hold req_valid high while busy -> no extra acceptance.
  - Request presented in the done cycle is accepted -> second pulse starts the next cycle.
  - Assert S&R==0 every cycle throughout all tests.
